vram_arbiter: RTL

Single-port video-memory arbiter for the Vector-06C core. It shares the 32-bit, four-plane video RAM between the display fetch and the CPU. The display fetch has absolute priority and a fixed 2-cycle latency; CPU byte accesses use a req/ack handshake and are serviced in the remaining slots. The block sits between the video timing block (`vaddr`/`vdata`), the CPU memory decoder, and the video RAM.

---
 rtl/vram_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - video/CPU arbiter for the shared four-plane video RAM (optional VRAM_ARB_STATS_EN)
module vram_arbiter #(
   parameter int AW = 13
) (
   input  logic          clk_sys,
   input  logic          reset_n,
   input  logic          vid_req,
   input  logic [AW-1:0] vid_addr,
   output logic [31:0]   vid_data,
   output logic          vid_valid,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW+1:0] cpu_addr,
   input  logic [7:0]    cpu_din,
   output logic [7:0]    cpu_dout,
   output logic          cpu_ack,
   output logic [AW-1:0] mem_addr,
   output logic          mem_we,
   output logic [3:0]    mem_be,
   output logic [31:0]   mem_d,
   input  logic [31:0]   mem_q,
   output logic [15:0]   stall_cnt
);

   typedef enum logic [1:0] {S_IDLE, S_WR_ACK, S_RD_WAIT, S_RD_ACK} state_t;
   typedef enum logic [1:0] {T_NONE, T_VID, T_CPU} tag_t;

   state_t        state_q, state_d;
   tag_t          t1_q, t1_d, t2_q, t2_d;
   logic [1:0]    plane_q, plane_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic          mem_we_q, mem_we_d;
   logic [3:0]    mem_be_q, mem_be_d;
   logic [31:0]   mem_d_q, mem_d_d;
   logic [31:0]   vid_data_q, vid_data_d;
   logic          vid_valid_q, vid_valid_d;
   logic [7:0]    cpu_dout_q, cpu_dout_d;
   logic          cpu_ack_q, cpu_ack_d;
   logic          cpu_eligible;
   logic          cpu_issue;

   // A CPU access may start only from IDLE, outside the ack cycle; video always wins the slot
   assign cpu_eligible = (state_q == S_IDLE) && cpu_req && !cpu_ack_q;
   assign cpu_issue    = cpu_eligible && !vid_req;

   // Issue slot, two-stage tag pipeline, completion and CPU handshake FSM
   always_comb begin
      state_d     = state_q;
      t1_d        = T_NONE;
      t2_d        = t1_q;
      plane_d     = plane_q;
      mem_addr_d  = mem_addr_q;
      mem_we_d    = 1'b0;
      mem_be_d    = 4'h0;
      mem_d_d     = mem_d_q;
      vid_data_d  = vid_data_q;
      vid_valid_d = 1'b0;
      cpu_dout_d  = cpu_dout_q;
      cpu_ack_d   = 1'b0;

      if (vid_req) begin
         mem_addr_d = vid_addr;
         mem_be_d   = 4'hF;
         t1_d       = T_VID;
      end else if (cpu_issue) begin
         mem_addr_d = cpu_addr[AW-1:0];
         mem_be_d   = 4'b0001 << cpu_addr[AW+1:AW];
         mem_d_d    = {4{cpu_din}};
         mem_we_d   = cpu_we;
         plane_d    = cpu_addr[AW+1:AW];
         if (!cpu_we) begin
            t1_d = T_CPU;
         end
      end

      if (t2_q == T_VID) begin
         vid_data_d  = mem_q;
         vid_valid_d = 1'b1;
      end else if (t2_q == T_CPU) begin
         cpu_dout_d = mem_q[{plane_q, 3'b000} +: 8];
         cpu_ack_d  = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (cpu_issue) begin
               state_d = cpu_we ? S_WR_ACK : S_RD_WAIT;
            end
         end
         S_WR_ACK: begin
            cpu_ack_d = 1'b1;
            state_d   = S_IDLE;
         end
         S_RD_WAIT: begin
            if (t2_q == T_CPU) begin
               state_d = S_RD_ACK;
            end
         end
         S_RD_ACK: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers; reset drops any in-flight access without ack
   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         t1_q        <= T_NONE;
         t2_q        <= T_NONE;
         plane_q     <= 2'd0;
         mem_addr_q  <= '0;
         mem_we_q    <= 1'b0;
         mem_be_q    <= 4'h0;
         mem_d_q     <= 32'h0;
         vid_data_q  <= 32'h0;
         vid_valid_q <= 1'b0;
         cpu_dout_q  <= 8'h0;
         cpu_ack_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         t1_q        <= t1_d;
         t2_q        <= t2_d;
         plane_q     <= plane_d;
         mem_addr_q  <= mem_addr_d;
         mem_we_q    <= mem_we_d;
         mem_be_q    <= mem_be_d;
         mem_d_q     <= mem_d_d;
         vid_data_q  <= vid_data_d;
         vid_valid_q <= vid_valid_d;
         cpu_dout_q  <= cpu_dout_d;
         cpu_ack_q   <= cpu_ack_d;
      end
   end

   assign mem_addr  = mem_addr_q;
   assign mem_we    = mem_we_q;
   assign mem_be    = mem_be_q;
   assign mem_d     = mem_d_q;
   assign vid_data  = vid_data_q;
   assign vid_valid = vid_valid_q;
   assign cpu_dout  = cpu_dout_q;
   assign cpu_ack   = cpu_ack_q;

`ifdef VRAM_ARB_STATS_EN
   logic [15:0] stall_q, stall_d;

   // Count cycles where a ready CPU access lost the slot to video, saturating
   always_comb begin
      stall_d = stall_q;
      if (cpu_eligible && vid_req && (stall_q != 16'hFFFF)) begin
         stall_d = stall_q + 16'd1;
      end
   end

   // Stall counter register
   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         stall_q <= 16'h0;
      end else begin
         stall_q <= stall_d;
      end
   end

   assign stall_cnt = stall_q;
`else
   assign stall_cnt = 16'h0000;
`endif

endmodule
